instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the control decoder in the RISC-V single-cycle core.
- Owns the PC register and runs a request/ready handshake with instruction memory.
- Holds the fetched word stable, with its opcode, until the core consumes it.
- Applies branch/jump redirects and tolerates variable-latency memory.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word driven on instr_o while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_ready_i  input  1  memory has rdata for the current request.
- imem_rdata_i  input  32  instruction word from memory.
- stall_i  input  1  core not ready to consume the held instruction.
- branch_taken_i  input  1  branch resolved taken for the held instruction.
- jal_i  input  1  jal/jalr redirect for the held instruction.
- target_addr_i  input  32  redirect target address.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  fetch address (equals pc_o).
- instr_o  output  32  held instruction, or NOP_INSTR.
- opcode_o  output  7  instr_o[6:0], feeds the control decoder.
- pc_o  output  32  PC of the held/being-fetched instruction.
- pc_plus4_o  output  32  pc_o + 4, link value for jal/jalr.
- instr_valid_o  output  1  instr_o holds a fetched instruction.

Behaviour:
- Reset (async, any state, including mid-handshake):
  - state = BOOT, pc = RESET_PC, instr register = NOP_INSTR.
  - imem_req_o = 0, instr_valid_o = 0, opcode_o = 7'b0010011.
- States BOOT, FETCH, HOLD.
  - BOOT: one idle cycle after reset deasserts, then FETCH.
  - FETCH:
    - imem_req_o = 1, imem_addr_o = pc; address and req stay stable until imem_ready_i.
    - On imem_ready_i: latch imem_rdata_i, go to HOLD.
    - instr_valid_o = 1 starting the next cycle.
    - Minimum latency request→valid = 1 cycle after ready; same-cycle ready is supported.
  - HOLD:
    - imem_req_o = 0; instr_o and pc_o stable.
    - If stall_i = 1: stay, and ignore redirect inputs this cycle.
    - If stall_i = 0: consume. pc ← target_addr_i if (branch_taken_i | jal_i), else pc + 4.
    - Then instr_valid_o = 0 and state = FETCH on the next cycle.
- Redirect inputs are sampled only in HOLD with stall_i = 0; ignored in BOOT and FETCH.
- branch_taken_i and jal_i both high: single redirect to target_addr_i.
- imem_ready_i outside FETCH is ignored; rdata is not latched.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- pc_plus4_o = pc_o + 4, combinational from the pc register, same wrap rule.
- When instr_valid_o = 0, instr_o = NOP_INSTR, so the decoder never sees a stale opcode.
- No outputs depend combinationally on imem_rdata_i; instr_o is registered.

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - A redirect with target_addr_i[1:0] != 2'b00: pc is not updated, misalign_o is set sticky until reset, and state stays HOLD with instr_valid_o = 1. The fetch unit freezes.
- Not defined:
  - No misalign_o port.
  - Target low bits are forced to 2'b00 before loading pc.

Test Plan:
- Reset release, memory ready 1 cycle after req, rdata 32'h0000_0293, stall_i = 0:
  - imem_addr_o = 32'h0040_0000; instr_valid_o = 1, opcode_o = 7'b0010011.
  - Next fetch address = 32'h0040_0004.
- Memory ready delayed 3 cycles:
  - imem_req_o held high and imem_addr_o constant for all 3 cycles; instr_o = NOP_INSTR until latched.
- HOLD with stall_i = 1 for 4 cycles and branch_taken_i pulsed during the stall:
  - pc_o and instr_o unchanged; pulse ignored.
  - On release with no redirect, next fetch address = pc + 4.
- HOLD at pc 32'h0040_0010, jal_i = 1, target 32'h0040_0100, stall_i = 0:
  - Next imem_addr_o = 32'h0040_0100; pc_plus4_o before the redirect = 32'h0040_0014.
- Redirect to 32'hFFFF_FFFC, then consume with no redirect:
  - Next fetch address = 32'h0000_0000.
- reset asserted mid-FETCH while waiting on ready:
  - imem_req_o = 0 and pc_o = 32'h0040_0000 in the same cycle, without a clock edge.
  - With IFU_MISALIGN_CHECK_EN, target 32'h0040_0102: misalign_o = 1, pc unchanged.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, handshakes with instruction memory, holds the fetched word for decode.
// Optional IFU_MISALIGN_CHECK_EN: adds sticky misalign_o and freezes on a misaligned redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic        jal_i,
  input  logic [31:0] target_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic        misalign_o,
`endif
  output logic        instr_valid_o
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        redirect;

`ifdef IFU_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
`endif

  assign redirect = branch_taken_i | jal_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
`ifdef IFU_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef IFU_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef IFU_MISALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (imem_ready_i) begin
          instr_d = imem_rdata_i;
          state_d = HOLD;
        end
      end
      HOLD: begin
`ifdef IFU_MISALIGN_CHECK_EN
        // once misaligned, the unit stays parked in HOLD until reset
        if (!stall_i && !mis_q) begin
          if (redirect && (target_addr_i[1:0] != 2'b00)) begin
            mis_d = 1'b1;
          end else begin
            pc_d    = redirect ? target_addr_i : pc_q + 32'd4;
            state_d = FETCH;
          end
        end
`else
        if (!stall_i) begin
          pc_d    = redirect ? (target_addr_i & ~32'h3) : pc_q + 32'd4;
          state_d = FETCH;
        end
`endif
      end
      default: state_d = BOOT;
    endcase
  end

  assign imem_req_o    = (state_q == FETCH);
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign instr_valid_o = (state_q == HOLD);
  // decoder must never see a stale opcode while nothing valid is held
  assign instr_o       = instr_valid_o ? instr_q : NOP_INSTR;
  assign opcode_o      = instr_o[6:0];
`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign_o    = mis_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized + directed bench for instruction_fetch_unit against a transaction-level PC/instruction model.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0, reset = 1'b1;
  logic        imem_ready_i = 1'b0, stall_i = 1'b0, branch_taken_i = 1'b0, jal_i = 1'b0;
  logic [31:0] imem_rdata_i = '0, target_addr_i = '0;
  logic        imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_o, pc_o, pc_plus4_o;
  logic [6:0]  opcode_o;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int n_chk = 0, n_fail = 0;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .branch_taken_i(branch_taken_i), .jal_i(jal_i),
    .target_addr_i(target_addr_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .instr_o(instr_o),
    .opcode_o(opcode_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
`ifdef IFU_MISALIGN_CHECK_EN
    .misalign_o(misalign_o),
`endif
    .instr_valid_o(instr_valid_o)
  );

  always #5 clk = ~clk;

  // model: waiting-for-boot flag, current PC, and the held word (if any)
  logic        m_boot, m_valid, m_mis;
  logic [31:0] m_pc, m_instr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_valid = 1'b0; m_mis = 1'b0; m_pc = RST_PC; m_instr = NOP;
  endtask

  task automatic model_step(input logic rdy, input logic [31:0] rd, input logic st,
                            input logic br, input logic jl, input logic [31:0] tg);
    if (m_boot) m_boot = 1'b0;
    else if (m_mis) ;
    else if (!m_valid) begin
      if (rdy) begin m_valid = 1'b1; m_instr = rd; end
    end else if (!st) begin
      if (br || jl) begin
`ifdef IFU_MISALIGN_CHECK_EN
        if (tg % 4 != 0) m_mis = 1'b1;
        else begin m_pc = tg; m_valid = 1'b0; end
`else
        m_pc = tg - (tg % 4); m_valid = 1'b0;
`endif
      end else begin
        m_pc = m_pc + 32'd4; m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] ei;
    ei = m_valid ? m_instr : NOP;
    chk("req",    {31'd0, imem_req_o},    {31'd0, !m_boot && !m_valid});
    chk("addr",   imem_addr_o,            m_pc);
    chk("pc",     pc_o,                   m_pc);
    chk("pc4",    pc_plus4_o,             m_pc + 32'd4);
    chk("valid",  {31'd0, instr_valid_o}, {31'd0, m_valid});
    chk("instr",  instr_o,                ei);
    chk("opcode", {25'd0, opcode_o},      {25'd0, ei[6:0]});
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis",    {31'd0, misalign_o},    {31'd0, m_mis});
`endif
  endtask

  // drive at negedge, step model at posedge, compare at the following negedge
  task automatic cyc(input logic rdy, input logic [31:0] rd, input logic st,
                     input logic br, input logic jl, input logic [31:0] tg);
    imem_ready_i = rdy; imem_rdata_i = rd; stall_i = st;
    branch_taken_i = br; jal_i = jl; target_addr_i = tg;
    @(posedge clk);
    model_step(rdy, rd, st, br, jl, tg);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_opcode", {25'd0, opcode_o}, 32'h13);
    reset = 1'b0;

    // boot, then single-cycle memory
    cyc(0, 0, 0, 0, 0, 0);
    chk("first_addr", imem_addr_o, 32'h0040_0000);
    cyc(1, 32'h0000_0293, 1, 0, 0, 0);
    chk("first_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("first_op", {25'd0, opcode_o}, 32'h13);
    cyc(0, 0, 0, 0, 0, 0);
    chk("next_addr", imem_addr_o, 32'h0040_0004);

    // ready delayed 3 cycles
    repeat (3) begin
      cyc(0, $urandom, 0, 0, 0, 0);
      chk("wait_req", {31'd0, imem_req_o}, 32'd1);
      chk("wait_addr", imem_addr_o, 32'h0040_0004);
      chk("wait_nop", instr_o, NOP);
    end
    cyc(1, 32'h00A0_0093, 0, 0, 0, 0);

    // stall 4 cycles with a branch pulse that must be ignored
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, i == 1, 0, 32'h1234_5678);
    chk("stall_instr", instr_o, 32'h00A0_0093);
    cyc(0, 0, 0, 0, 0, 0);
    chk("after_stall", imem_addr_o, 32'h0040_0008);

    // walk to 0x0040_0010 then jal
    cyc(1, 32'h0000_0013, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h0000_0013, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h0040_006F, 0, 0, 0, 0);
    chk("jal_pc", pc_o, 32'h0040_0010);
    chk("jal_pc4", pc_plus4_o, 32'h0040_0014);
    cyc(0, 0, 0, 0, 1, 32'h0040_0100);
    chk("jal_tgt", imem_addr_o, 32'h0040_0100);

    // both redirect inputs, then wrap from 0xFFFF_FFFC
    cyc(1, 32'h0000_0063, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_tgt", imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_o, 32'h0000_0000);
    cyc(1, 32'h0000_0013, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr_o, 32'h0000_0000);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tg;
      tg = $urandom;
`ifdef IFU_MISALIGN_CHECK_EN
      tg[1:0] = 2'b00;
`endif
      cyc($urandom_range(0, 9) < 5, $urandom, $urandom_range(0, 9) < 4,
          $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1, tg);
    end

    // reach FETCH and assert reset asynchronously while waiting on ready
    for (int i = 0; i < 4 && (m_valid || m_boot); i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pre_rst_req", {31'd0, imem_req_o}, 32'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_req", {31'd0, imem_req_o}, 32'd0);
    chk("async_pc", pc_o, 32'h0040_0000);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // misaligned redirect
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h0000_0013, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0040_0102);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_pc", pc_o, 32'h0040_0000);
`else
    chk("mask_pc", pc_o, 32'h0040_0100);
`endif
    cyc(1, 32'h0000_0033, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
